// File: rtl/xdma_pkg.sv
// Shared types and constants for the xDMA write-burst path.
//   AXI_BURST_INCR    : AXI INCR burst encoding
//   DEFAULT_PAGE_SIZE : default boundary that no burst may cross
//   split_state_e     : burst-splitter FSM states
//   aw_desc_t         : AW fields that do not depend on bus/address width
//   w_desc_t          : W-side burst descriptor (beats, single, last)
package xdma_pkg;

  localparam logic [1:0]  AXI_BURST_INCR    = 2'b01;
  localparam int unsigned DEFAULT_PAGE_SIZE = 4096;

  typedef enum logic {
    IDLE,
    ISSUE
  } split_state_e;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       is_data;
  } aw_desc_t;

  typedef struct packed {
    logic [8:0] num_beats;
    logic       is_single;
    logic       last_burst;
  } w_desc_t;

endpackage

// File: rtl/xdma_burst_len_calc.sv
// Combinational burst sizer: beats = min(rem, MaxBeats, beats left in page).
// Shared by the read and write burst splitters.
//   cur_addr_i : current (beat-aligned) burst address
//   rem_i      : beats still to issue for the descriptor
//   beats_o    : beats in the burst starting at cur_addr_i
//   last_o     : this burst finishes the descriptor
module xdma_burst_len_calc #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned StrbWidth = 64,
  parameter int unsigned PageSize  = 4096,
  parameter int unsigned MaxBeats  = 64
) (
  input  logic [AddrWidth-1:0] cur_addr_i,
  input  logic [LenWidth-1:0]  rem_i,
  output logic [8:0]           beats_o,
  output logic                 last_o
);

  localparam int unsigned PageBits = $clog2(PageSize);
  localparam int unsigned SizeBits = $clog2(StrbWidth);
  localparam int unsigned PW       = PageBits + 1;
  localparam logic [PW-1:0] PageSizeW = PW'(PageSize);
  localparam logic [PW-1:0] MaxBeatsW = PW'(MaxBeats);

  logic [PW-1:0]       room_beats;
  logic [8:0]          cap;
  logic [LenWidth-1:0] cap_w;

  // Only the page offset matters for the boundary; upper bits are unused here.
  logic unused_addr_msb;
  assign unused_addr_msb = ^cur_addr_i[AddrWidth-1:PageBits];

  always_comb begin
    room_beats = (PageSizeW - {1'b0, cur_addr_i[PageBits-1:0]}) >> SizeBits;
    // room_beats can be wider than 9 bits; truncation only happens below MaxBeats
    cap        = (room_beats < MaxBeatsW) ? 9'(room_beats) : 9'(MaxBeats);
    cap_w      = LenWidth'(cap);
    beats_o    = (rem_i < cap_w) ? 9'(rem_i) : cap;
    last_o     = (rem_i <= cap_w);
  end

endmodule

// File: rtl/xdma_burst_splitter.sv
// xDMA write-burst splitter: accepts one descriptor (addr, len in beats, id,
// is_data) and emits AXI AW+W descriptor pairs, each capped at MaxBeats and
// never crossing a PageSize boundary.
//   clk_i, rst_i (async, active-high)
//   req_*   : descriptor valid/ready handshake input
//   out_*   : AW+W descriptor pair valid/ready output
//   aw_*    : burst id/addr/len/size/burst/is_data
//   w_*     : beats in burst, single-beat flag, last burst of descriptor
//   done_o  : one-cycle pulse after the descriptor is fully issued
// Optional macro XDMA_BURST_SPLITTER_PERF_EN adds saturating 32-bit counters
// perf_bursts_o (output handshakes) and perf_stalls_o (valid & !ready cycles).
module xdma_burst_splitter
  import xdma_pkg::*;
#(
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned IdWidth       = 4,
  parameter int unsigned DataWidth     = 512,
  parameter int unsigned StrbWidth     = DataWidth / 8,
  parameter int unsigned PageSize      = DEFAULT_PAGE_SIZE,
  parameter int unsigned MaxBurstBeats = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic                 req_is_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IdWidth-1:0]   aw_id_o,
  output logic [AddrWidth-1:0] aw_addr_o,
  output logic [7:0]           aw_len_o,
  output logic [2:0]           aw_size_o,
  output logic [1:0]           aw_burst_o,
  output logic                 aw_is_data_o,
  output logic [8:0]           w_num_beats_o,
  output logic                 w_is_single_o,
  output logic                 w_last_burst_o,
  output logic                 done_o
`ifdef XDMA_BURST_SPLITTER_PERF_EN
  ,
  output logic [31:0]          perf_bursts_o,
  output logic [31:0]          perf_stalls_o
`endif
);

  localparam int unsigned SizeBits = $clog2(StrbWidth);
  localparam int unsigned MaxBeats = (MaxBurstBeats < PageSize / StrbWidth)
                                     ? MaxBurstBeats : PageSize / StrbWidth;

  split_state_e         state_q;
  logic [IdWidth-1:0]   id_q;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  rem_q, rem_d;
  logic                 is_data_q;
  logic                 done_q;

  logic [8:0] beats;
  logic       last;
  aw_desc_t   aw;
  w_desc_t    w;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr_i[SizeBits-1:0];

  xdma_burst_len_calc #(
    .AddrWidth(AddrWidth),
    .LenWidth (LenWidth),
    .StrbWidth(StrbWidth),
    .PageSize (PageSize),
    .MaxBeats (MaxBeats)
  ) u_len_calc (
    .cur_addr_i(addr_q),
    .rem_i     (rem_q),
    .beats_o   (beats),
    .last_o    (last)
  );

  assign addr_d = addr_q + (AddrWidth'(beats) << SizeBits);
  assign rem_d  = rem_q - LenWidth'(beats);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      is_data_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            id_q      <= req_id_i;
            addr_q    <= {req_addr_i[AddrWidth-1:SizeBits], {SizeBits{1'b0}}};
            rem_q     <= req_len_i;
            is_data_q <= req_is_data_i;
            // Zero-length descriptors complete without emitting a burst.
            if (req_len_i != '0) state_q <= ISSUE;
            else                 done_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (out_ready_i) begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
            if (last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign out_valid_o = (state_q == ISSUE);
  assign done_o      = done_q;

  // Descriptor fields read zero whenever no burst is offered.
  always_comb begin
    aw = '0;
    w  = '0;
    if (out_valid_o) begin
      aw.len       = 8'(beats - 9'd1);
      aw.size      = 3'(SizeBits);
      aw.burst     = AXI_BURST_INCR;
      aw.is_data   = is_data_q;
      w.num_beats  = beats;
      w.is_single  = (beats == 9'd1);
      w.last_burst = last;
    end
  end

  assign aw_id_o        = out_valid_o ? id_q   : '0;
  assign aw_addr_o      = out_valid_o ? addr_q : '0;
  assign aw_len_o       = aw.len;
  assign aw_size_o      = aw.size;
  assign aw_burst_o     = aw.burst;
  assign aw_is_data_o   = aw.is_data;
  assign w_num_beats_o  = w.num_beats;
  assign w_is_single_o  = w.is_single;
  assign w_last_burst_o = w.last_burst;

`ifdef XDMA_BURST_SPLITTER_PERF_EN
  logic [31:0] perf_bursts_q, perf_stalls_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_bursts_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (out_valid_o && out_ready_i && (perf_bursts_q != '1))
        perf_bursts_q <= perf_bursts_q + 32'd1;
      if (out_valid_o && !out_ready_i && (perf_stalls_q != '1))
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_bursts_o = perf_bursts_q;
  assign perf_stalls_o = perf_stalls_q;
`endif

endmodule

// File: tb/tb_xdma_burst_splitter.sv
// Self-checking bench for xdma_burst_splitter (DataWidth=512, PageSize=4096).
// Expected bursts come from a plain arithmetic model of the splitting rules.
module tb_xdma_burst_splitter;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_id;
  logic [47:0] req_addr;
  logic [31:0] req_len;
  logic        req_is_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  aw_id;
  logic [47:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        aw_is_data;
  logic [8:0]  w_num_beats;
  logic        w_is_single;
  logic        w_last_burst;
  logic        done;
`ifdef XDMA_BURST_SPLITTER_PERF_EN
  logic [31:0] perf_bursts;
  logic [31:0] perf_stalls;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned exp_bursts = 0;
  int unsigned exp_stalls = 0;

  typedef struct {
    logic [47:0] addr;
    logic [8:0]  beats;
    logic        last;
  } burst_t;

  xdma_burst_splitter #(
    .AddrWidth    (48),
    .LenWidth     (32),
    .IdWidth      (4),
    .DataWidth    (512),
    .StrbWidth    (64),
    .PageSize     (4096),
    .MaxBurstBeats(256)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_id_i      (req_id),
    .req_addr_i    (req_addr),
    .req_len_i     (req_len),
    .req_is_data_i (req_is_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .aw_id_o       (aw_id),
    .aw_addr_o     (aw_addr),
    .aw_len_o      (aw_len),
    .aw_size_o     (aw_size),
    .aw_burst_o    (aw_burst),
    .aw_is_data_o  (aw_is_data),
    .w_num_beats_o (w_num_beats),
    .w_is_single_o (w_is_single),
    .w_last_burst_o(w_last_burst),
    .done_o        (done)
`ifdef XDMA_BURST_SPLITTER_PERF_EN
    ,
    .perf_bursts_o (perf_bursts),
    .perf_stalls_o (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_perf();
`ifdef XDMA_BURST_SPLITTER_PERF_EN
    check("perf_bursts", 64'(perf_bursts), 64'(exp_bursts));
    check("perf_stalls", 64'(perf_stalls), 64'(exp_stalls));
`endif
  endtask

  // Reference: walk the descriptor page by page, capped at 64 beats (4096/64).
  task automatic model(input logic [47:0] addr, input logic [31:0] len, output burst_t q[$]);
    logic [47:0] a;
    longint unsigned r, room, b;
    q = {};
    a = addr & ~48'h3F;
    r = len;
    while (r != 0) begin
      room = (4096 - (a % 4096)) / 64;
      b = r;
      if (b > 64) b = 64;
      if (b > room) b = room;
      q.push_back('{a, 9'(b), (r == b)});
      a = a + 48'(b * 64);
      r = r - b;
    end
  endtask

  // Entered and left at a negedge; drives the descriptor right away so a new
  // request overlaps the previous done_o cycle.
  task automatic run_desc(input logic [47:0] addr, input logic [31:0] len,
                          input logic [3:0] id, input logic isd,
                          input int unsigned pct, input int stall_burst,
                          input int unsigned stall_cycles);
    burst_t q[$];
    int unsigned idx = 0, hold = 0, budget = 0;
    bit held = 0;
    logic rdy;
    model(addr, len, q);
    check("accept_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = addr; req_len = len; req_id = id; req_is_data = isd;
    @(negedge clk);
    // Scramble request inputs; they must be ignored while issuing.
    req_valid = (len != 0) ? 1'($urandom) : 1'b0;
    req_addr = {16'($urandom), $urandom};
    req_len = $urandom; req_id = 4'($urandom); req_is_data = 1'($urandom);
    while (q.size() != 0 && budget < 4000) begin
      check("out_valid", 64'(out_valid), 64'd1);
      check("req_ready_busy", 64'(req_ready), 64'd0);
      check("done_busy", 64'(done), 64'd0);
      check("aw_addr", 64'(aw_addr), 64'(q[0].addr));
      check("aw_len", 64'(aw_len), 64'(q[0].beats - 9'd1));
      check("w_num_beats", 64'(w_num_beats), 64'(q[0].beats));
      check("w_is_single", 64'(w_is_single), 64'(q[0].beats == 9'd1));
      check("w_last_burst", 64'(w_last_burst), 64'(q[0].last));
      check("aw_id", 64'(aw_id), 64'(id));
      check("aw_is_data", 64'(aw_is_data), 64'(isd));
      check("aw_size", 64'(aw_size), 64'd6);
      check("aw_burst", 64'(aw_burst), 64'd1);
      if (!held && stall_burst >= 0 && idx == int'(stall_burst)) begin
        hold = stall_cycles; held = 1;
      end
      if (hold > 0) begin rdy = 1'b0; hold--; end
      else rdy = ($urandom_range(0, 99) < pct);
      if (rdy) exp_bursts++; else exp_stalls++;
      out_ready = rdy;
      @(negedge clk);
      budget++;
      if (rdy) begin void'(q.pop_front()); idx++; end
    end
    if (q.size() != 0) check("burst_budget", 64'(q.size()), 64'd0);
    req_valid = 1'b0;
    out_ready = 1'($urandom);
    check("done_pulse", 64'(done), 64'd1);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_ready", 64'(req_ready), 64'd1);
    check("idle_aw_len", 64'(aw_len), 64'd0);
    check_perf();
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; req_id = 0; req_addr = 0; req_len = 0;
    req_is_data = 0; out_ready = 0;
    #12;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aw_addr", 64'(aw_addr), 64'd0);
    check("rst_num_beats", 64'(w_num_beats), 64'd0);
    check("rst_aw_size", 64'(aw_size), 64'd0);
    check_perf();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_desc(48'h0, 32'd130, 4'h3, 1'b1, 100, -1, 0);        // 64/64/2
    run_desc(48'hF80, 32'd4, 4'h5, 1'b0, 100, -1, 0);        // page crossing
    run_desc(48'h40, 32'd1, 4'h7, 1'b1, 100, -1, 0);         // single beat
    run_desc(48'h2000, 32'd100, 4'h9, 1'b1, 100, 1, 5);      // 5-cycle stall
    run_desc(48'h123, 32'd0, 4'h1, 1'b0, 100, -1, 0);        // zero length
    run_desc(48'hFBF, 32'd3, 4'h2, 1'b1, 100, -1, 0);        // unaligned start
    run_desc(48'hFFFF_FFFF_FFC0, 32'd3, 4'hA, 1'b0, 100, -1, 0); // address wrap
    run_desc(48'h0, 32'd0, 4'h4, 1'b1, 100, -1, 0);          // back-to-back zero

    // Reset during the second of three bursts.
    req_valid = 1'b1; req_addr = 48'h0; req_len = 32'd130; req_id = 4'h6; req_is_data = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mr_first_addr", 64'(aw_addr), 64'h0);
    @(negedge clk);
    check("mr_second_addr", 64'(aw_addr), 64'h1000);
    #2 rst = 1'b1;
    #1;
    check("mr_valid_drop", 64'(out_valid), 64'd0);
    check("mr_done", 64'(done), 64'd0);
    check("mr_ready", 64'(req_ready), 64'd0);
    check("mr_aw_addr", 64'(aw_addr), 64'd0);
    check("mr_aw_len", 64'(aw_len), 64'd0);
    exp_bursts = 0; exp_stalls = 0;
    check_perf();
    @(negedge clk);
    check("mr_done_hold", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mr_done_after", 64'(done), 64'd0);
    check("mr_valid_after", 64'(out_valid), 64'd0);
    run_desc(48'h5000_0040, 32'd70, 4'hC, 1'b0, 100, -1, 0);

    // Randomized descriptors with random backpressure.
    for (int n = 0; n < 40; n++) begin
      logic [47:0] a;
      logic [31:0] l;
      a = {16'($urandom), $urandom};
      l = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
      run_desc(a, l, 4'($urandom), 1'($urandom), 70, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
